// File: rtl/gps_pkg.sv
// Shared constants for the GPS command transmitter: ASCII framing bytes,
// command-select encodings and the PMTK sentence body ROM.
`timescale 1ns/1ps
package gps_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    typedef enum logic [1:0] {
        CMD_RMC_ONLY  = 2'd0,
        CMD_RATE_1HZ  = 2'd1,
        CMD_RATE_5HZ  = 2'd2,
        CMD_RATE_10HZ = 2'd3
    } cmd_sel_e;

    localparam int IDX_W    = 6;
    localparam int LEN_RMC  = 45;
    localparam int LEN_1HZ  = 12;
    localparam int LEN_5HZ  = 11;
    localparam int LEN_10HZ = 11;

    // Nineteen output-rate fields; only the second (RMC) is enabled.
    localparam logic [8*LEN_RMC-1:0] BODY_RMC = {
        "PMTK314,", "0,1,", "0,0,0,0,0,", "0,0,0,0,0,", "0,0,0,0,0,", "0,0"
    };
    localparam logic [8*LEN_1HZ-1:0]  BODY_1HZ  = "PMTK220,1000";
    localparam logic [8*LEN_5HZ-1:0]  BODY_5HZ  = "PMTK220,200";
    localparam logic [8*LEN_10HZ-1:0] BODY_10HZ = "PMTK220,100";

    function automatic logic [IDX_W-1:0] body_len(input cmd_sel_e sel);
        case (sel)
            CMD_RMC_ONLY: body_len = IDX_W'(LEN_RMC);
            CMD_RATE_1HZ: body_len = IDX_W'(LEN_1HZ);
            CMD_RATE_5HZ: body_len = IDX_W'(LEN_5HZ);
            default:      body_len = IDX_W'(LEN_10HZ);
        endcase
    endfunction

    // String literals pack the first character into the top byte.
    function automatic logic [7:0] body_byte(input cmd_sel_e sel, input logic [IDX_W-1:0] idx);
        body_byte = 8'h00;
        case (sel)
            CMD_RMC_ONLY:
                if (int'(idx) < LEN_RMC)  body_byte = BODY_RMC[8*(LEN_RMC-1-int'(idx)) +: 8];
            CMD_RATE_1HZ:
                if (int'(idx) < LEN_1HZ)  body_byte = BODY_1HZ[8*(LEN_1HZ-1-int'(idx)) +: 8];
            CMD_RATE_5HZ:
                if (int'(idx) < LEN_5HZ)  body_byte = BODY_5HZ[8*(LEN_5HZ-1-int'(idx)) +: 8];
            default:
                if (int'(idx) < LEN_10HZ) body_byte = BODY_10HZ[8*(LEN_10HZ-1-int'(idx)) +: 8];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer. A new byte can be taken on the last cycle of the
// previous stop bit, so consecutive bytes go out with no idle gap.
`timescale 1ns/1ps
module uart_tx #(
    parameter int DIV = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_byte_done,
    output logic       tx
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} phase_e;

    phase_e           phase;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             last_tick;

    assign last_tick    = (baud_cnt == LAST_CNT);
    assign tx_ready     = (phase == U_IDLE) || (phase == U_STOP && last_tick);
    // Fires as the stop bit begins, leaving the whole stop bit to fetch the next byte.
    assign tx_byte_done = (phase == U_DATA) && (bit_cnt == 3'd7) && last_tick;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= U_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else if (tx_ready && tx_start) begin
            phase    <= U_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= tx_data;
            tx       <= 1'b0;
        end else if (phase != U_IDLE) begin
            if (!last_tick) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (phase)
                    U_START: begin
                        phase <= U_DATA;
                        tx    <= shift[0];
                    end
                    U_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            phase <= U_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end
                    default: begin
                        phase <= U_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gps_cmd_tx.sv
// Sends one PMTK configuration sentence ($body*HH<CR><LF>) to a GPS receiver,
// computing the XOR checksum on the fly as the body is serialized.
`timescale 1ns/1ps
module gps_cmd_tx
    import gps_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd_sel,
    input  logic       cmd_start,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       gps_tx
);

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;

    typedef enum logic [3:0] {IDLE, SOF, BODY, STAR, CKH, CKL, CR, LF, FIN} ctrl_state_e;

    ctrl_state_e      state;
    cmd_sel_e         sel_q;
    logic [IDX_W-1:0] body_idx;
    logic [7:0]       checksum;
    logic [7:0]       cur_body;
    logic             tx_start;
    logic             tx_ready;
    logic             tx_byte_done;
    logic [7:0]       tx_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign cur_body = body_byte(sel_q, body_idx);

    // The state names the byte on the line; it moves on when that byte's stop
    // bit begins, so tx_data already holds the next byte when the UART frees up.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        tx_start = 1'b1;
        tx_data  = ASCII_DOLLAR;
        case (state)
            SOF:     tx_data = ASCII_DOLLAR;
            BODY:    tx_data = cur_body;
            STAR:    tx_data = ASCII_STAR;
            CKH:     tx_data = hex_ascii(checksum[7:4]);
            CKL:     tx_data = hex_ascii(checksum[3:0]);
            CR:      tx_data = ASCII_CR;
            LF:      tx_data = ASCII_LF;
            default: tx_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= CMD_RMC_ONLY;
            body_idx <= '0;
            checksum <= '0;
            cmd_busy <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        sel_q    <= cmd_sel_e'(cmd_sel);
                        checksum <= '0;
                        cmd_busy <= 1'b1;
                        state    <= SOF;
                    end
                end
                SOF: begin
                    body_idx <= '0;
                    if (tx_byte_done) state <= BODY;
                end
                BODY: begin
                    if (tx_byte_done) begin
                        checksum <= checksum ^ cur_body;
                        if (body_idx == body_len(sel_q) - IDX_W'(1)) begin
                            body_idx <= '0;
                            state    <= STAR;
                        end else begin
                            body_idx <= body_idx + 1'b1;
                        end
                    end
                end
                STAR: if (tx_byte_done) state <= CKH;
                CKH:  if (tx_byte_done) state <= CKL;
                CKL:  if (tx_byte_done) state <= CR;
                CR:   if (tx_byte_done) state <= LF;
                LF:   if (tx_byte_done) state <= FIN;
                FIN: begin
                    // The UART turns ready on the final cycle of the LF stop bit.
                    if (tx_ready) begin
                        state    <= IDLE;
                        cmd_busy <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx #(.DIV(DIV)) u_uart_tx (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tx_byte_done (tx_byte_done),
        .tx           (gps_tx)
    );

endmodule

// File: tb/tb_gps_cmd_tx.sv
// Scoreboard bench for gps_cmd_tx: expected sentence bytes are queued at
// stimulus time and a UART monitor decodes gps_tx and compares independently.
`timescale 1ns/1ps
module tb_gps_cmd_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 300;
    localparam int DIV    = 3;   // 1000/300 truncated

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd_sel = 2'd0;
    logic       cmd_start = 1'b0;
    logic       cmd_busy;
    logic       cmd_done;
    logic       gps_tx;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    logic [7:0] exp_q[$];

    logic [9:0] mon_bits;
    logic [7:0] mon_byte;
    logic       mon_v;
    bit         mon_abort;
    bit         mon_stable;
    logic [31:0] mon_exp;

    string s0, s1, s2, s3;

    always #5 clk = ~clk;

    gps_cmd_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_sel   (cmd_sel),
        .cmd_start (cmd_start),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done),
        .gps_tx    (gps_tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

    // UART monitor: samples every cycle of a frame so mid-bit transitions are caught.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && gps_tx === 1'b0) begin
                mon_abort  = 1'b0;
                mon_stable = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < DIV; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst) mon_abort = 1'b1;
                        if (s == 0) mon_v = gps_tx;
                        else if (gps_tx !== mon_v) mon_stable = 1'b0;
                    end
                    mon_bits[b] = mon_v;
                    if (mon_abort) break;
                end
                if (!mon_abort) begin
                    mon_byte = mon_bits[8:1];
                    mon_exp  = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100;
                    check("bit_width", {31'h0, mon_stable}, 32'd1);
                    check("stop_bit", {31'h0, mon_bits[9]}, 32'd1);
                    check("byte", {24'h0, mon_byte}, mon_exp);
                end
            end
        end
    end

    task automatic push_sentence(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Returns on the negedge where cmd_done is seen (or after an abort/timeout).
    task automatic run_sentence(input logic [1:0] sel, input string s, input int blen,
                                input bit chained, input int repulse_at, input int abort_at);
        int  m;
        int  lat;
        int  first_low;
        bit  seen;
        bit  aborted;
        m = (blen + 6) * 10 * DIV;
        push_sentence(s);
        if (!chained) @(negedge clk);
        cmd_sel   = sel;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        lat       = 1;
        first_low = -1;
        seen      = 1'b0;
        aborted   = 1'b0;
        check("busy_after_accept", {31'h0, cmd_busy}, 32'd1);
        while (lat < m + 50) begin
            if (gps_tx === 1'b0 && first_low < 0) first_low = lat;
            if (lat == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_gps_tx_high", {31'h0, gps_tx}, 32'd1);
                check("abort_busy_low", {31'h0, cmd_busy}, 32'd0);
                check("abort_done_low", {31'h0, cmd_done}, 32'd0);
                aborted = 1'b1;
                break;
            end
            if (lat == repulse_at) begin
                check("busy_during_repulse", {31'h0, cmd_busy}, 32'd1);
                cmd_sel   = 2'd3;
                cmd_start = 1'b1;
            end
            if (lat == repulse_at + 1) cmd_start = 1'b0;
            if (cmd_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!aborted) begin
            check("done_seen", {31'h0, seen}, 32'd1);
            if (seen) begin
                exp_done++;
                check_range("sentence_cycles", lat, m - 3, m + 3);
                check_range("start_latency", first_low, 1, 2);
                check("busy_low_at_done", {31'h0, cmd_busy}, 32'd0);
            end
        end
    endtask

    task automatic finish_check();
        @(negedge clk);
        check("done_one_cycle", {31'h0, cmd_done}, 32'd0);
        check("done_count", done_cnt, exp_done);
        check("bytes_all_seen", exp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        s0 = {"$PMTK314,", "0,1,", "0,0,0,0,0,", "0,0,0,0,0,", "0,0,0,0,0,", "0,0", "*29\r\n"};
        s1 = "$PMTK220,1000*1F\r\n";
        s2 = "$PMTK220,200*2C\r\n";
        s3 = "$PMTK220,100*2F\r\n";

        repeat (3) @(negedge clk);
        check("reset_gps_tx", {31'h0, gps_tx}, 32'd1);
        check("reset_busy", {31'h0, cmd_busy}, 32'd0);
        check("reset_done", {31'h0, cmd_done}, 32'd0);
        rst = 1'b0;

        run_sentence(2'd1, s1, 12, 1'b0, -1, -1);
        finish_check();

        run_sentence(2'd2, s2, 11, 1'b0, -1, -1);
        run_sentence(2'd3, s3, 11, 1'b1, -1, -1);
        finish_check();

        run_sentence(2'd0, s0, 45, 1'b0, -1, -1);
        finish_check();

        run_sentence(2'd1, s1, 12, 1'b0, 40, -1);
        finish_check();
        repeat (20 * DIV) @(negedge clk);
        check("no_queued_start_done", done_cnt, exp_done);
        check("no_queued_start_busy", {31'h0, cmd_busy}, 32'd0);

        run_sentence(2'd2, s2, 11, 1'b0, -1, 4 * 10 * DIV + 5);
        repeat (4) @(negedge clk);
        check("no_done_after_abort", done_cnt, exp_done);
        check("abort_held_gps_tx", {31'h0, gps_tx}, 32'd1);
        exp_q.delete();
        rst = 1'b0;

        run_sentence(2'd1, s1, 12, 1'b0, -1, -1);
        finish_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_cmd_tx.md
GPS_CMD_TX -- requirements
Module: gps_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: UART bit rate toward the GPS receiver.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_sel, input, 2: command select; 0=RMC-only output, 1=1 Hz, 2=5 Hz, 3=10 Hz update rate.
REQ-006 SHALL have port cmd_start, input, 1: request to send the selected command.
REQ-007 SHALL have port cmd_busy, output, 1: a sentence is being transmitted.
REQ-008 SHALL have port cmd_done, output, 1: one-cycle pulse when a sentence completes.
REQ-009 SHALL have port gps_tx, output, 1: UART serial line to the GPS module; idles high.

Function
REQ-010 SHALL transmit the sentence as '$', then body, then '*', then two uppercase ASCII hex checksum digits (high nibble first), then CR (0x0D), then LF (0x0A).
REQ-011 SHALL use these bodies: 0 = "PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0"; 1 = "PMTK220,1000"; 2 = "PMTK220,200"; 3 = "PMTK220,100".
REQ-012 SHALL compute the checksum at run time as an 8-bit XOR of the body bytes only, excluding '$' and '*'; checksums SHALL NOT be stored.
REQ-013 SHALL frame each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 SHALL make each bit last DIV = CLK_FREQ_HZ/BAUD_RATE clock cycles, with integer truncation (10416 at the defaults).
REQ-015 SHALL send the bytes of one sentence back-to-back: the next start bit begins on the cycle after the previous stop bit ends.
REQ-016 SHALL accept cmd_start only when cmd_busy is low; cmd_sel SHALL be sampled on that same edge and held internally.
REQ-017 SHALL ignore cmd_start while cmd_busy is high, with no queuing.
REQ-018 SHALL assert cmd_busy on the edge after acceptance.
REQ-019 SHALL drive the first start bit of gps_tx low no later than 2 cycles after acceptance.
REQ-020 SHALL pulse cmd_done for exactly one cycle at the end of the LF stop bit, and SHALL deassert cmd_busy on that same cycle.
REQ-021 SHALL accept a new cmd_start on the cycle after cmd_done.
REQ-022 SHALL make the sentence duration (body_len+6)*10*DIV cycles, within +/-3 cycles.
REQ-023 SHALL use controller FSM states IDLE, SOF, BODY, STAR, CKH, CKL, CR, LF, FIN, sequenced in that order with no skipped states.
REQ-024 SHALL advance the FSM only on byte-complete from the serializer.
REQ-025 SHALL hold the body index, which SHALL clear in SOF and wrap to 0 after the last body byte.
REQ-026 SHALL hex-encode a nibble 0-9 as 0x30-0x39 and a nibble A-F as 0x41-0x46.

Reset
REQ-027 SHALL, while rst is asserted, force gps_tx=1, cmd_busy=0, cmd_done=0, FSM=IDLE, checksum=0x00 and baud counter=0, asynchronously.
REQ-028 SHALL, if rst asserts mid-byte, abort the sentence with gps_tx returning high immediately and no cmd_done pulse.
REQ-029 SHALL, after rst deasserts, return to IDLE and accept cmd_start on the next edge.

Structure
REQ-030 SHALL place the ASCII constants ('$', '*', CR, LF), the command-select encodings and the body ROM with its lengths in the shared package gps_pkg.
REQ-031 SHALL implement the 8N1 serializer (baud counter, bit counter, shift register, tx_start/tx_data/tx_ready) as the sub-module uart_tx.
REQ-032 SHALL keep the controller FSM, the checksum XOR and the hex encoder in gps_cmd_tx.

Verification
REQ-033 SHALL test cmd_sel=1 with a cmd_start pulse: a UART monitor decodes "$PMTK220,1000*1F\r\n" (18 bytes), with cmd_done pulsed once at (12+6)*10*10416 cycles +/-3.
REQ-034 SHALL test cmd_sel=2, then cmd_sel=3 started on the cycle after cmd_done: the monitor decodes "$PMTK220,200*2C\r\n" then "$PMTK220,100*2F\r\n" with no idle gap beyond 2 cycles.
REQ-035 SHALL test cmd_sel=0: the monitor decodes "$PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0*29\r\n", and every bit width measures 10416 cycles.
REQ-036 SHALL test cmd_start re-pulsed with cmd_sel changed while busy: the sentence in flight is unchanged and exactly one cmd_done occurs.
REQ-037 SHALL test rst asserted during the 5th byte: gps_tx=1 and cmd_busy=0 within the same cycle, no cmd_done, and a following cmd_sel=1 start yields a complete, correct sentence.
REQ-038 SHALL test a bench parameter override CLK_FREQ_HZ=1000, BAUD_RATE=300: every bit lasts 3 cycles.
